// File: rtl/uart_rx_periph_if.sv
// rtl/uart_rx_periph_if.sv - SoC register bus bundle for the UART receive peripheral
interface uart_rx_periph_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] d_in;
    logic [15:0] d_out;

    modport master (
        output cs,
        output rd,
        output wr,
        output addr,
        output d_in,
        input  d_out
    );

    modport slave (
        input  cs,
        input  rd,
        input  wr,
        input  addr,
        input  d_in,
        output d_out
    );
endinterface

// File: rtl/uart_rx_periph.sv
// rtl/uart_rx_periph.sv - 8N1 UART receiver with 16x oversampling, byte FIFO and status registers
module uart_rx_periph #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic             uart_rx,
    uart_rx_periph_if.slave  bus,
    output logic             rx_led
);

    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic             rx_meta_q, rxs_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    state_t           state_q, state_d;
    logic [3:0]       tcnt_q, tcnt_d;
    logic [2:0]       bidx_q, bidx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             hold_q, hold_d;
    logic             push_req;
    logic             ferr_set;
    logic             rx_led_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             avail, full;
    logic             push, pop, ovr_set;

    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      d_out_q, d_out_d;
    logic             rd_en, wr_en;
    logic             unused_d_in;

    assign unused_d_in = ^{bus.d_in[15:4], bus.d_in[1:0]};

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Divider sits at zero in IDLE so the first tick lands DIV cycles after the falling edge
    assign tick = (state_q != IDLE) && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (state_q == IDLE || tick) begin
            div_d = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bidx_d   = bidx_q;
        shreg_d  = shreg_q;
        hold_d   = hold_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            IDLE: begin
                tcnt_d = 4'd0;
                hold_d = 1'b0;
                if (!rxs_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt_q == 4'd7) begin
                        tcnt_d  = 4'd0;
                        bidx_d  = 3'd0;
                        state_d = rxs_q ? IDLE : DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt_q == 4'd15) begin
                        shreg_d = {rxs_q, shreg_q[7:1]};
                        tcnt_d  = 4'd0;
                        if (bidx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bidx_d = bidx_q + 3'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                // After a bad stop bit, wait for the line to return high before rearming
                if (hold_q) begin
                    if (rxs_q) begin
                        hold_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (tick) begin
                    if (tcnt_q == 4'd15) begin
                        if (rxs_q) begin
                            push_req = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            hold_d   = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q  <= IDLE;
            div_q    <= '0;
            tcnt_q   <= 4'd0;
            bidx_q   <= 3'd0;
            shreg_q  <= 8'h00;
            hold_q   <= 1'b0;
            rx_led_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tcnt_q   <= tcnt_d;
            bidx_q   <= bidx_d;
            shreg_q  <= shreg_d;
            hold_q   <= hold_d;
            rx_led_q <= (state_d != IDLE);
        end
    end

    assign rx_led = rx_led_q;

    assign rd_en = bus.cs & bus.rd;
    assign wr_en = bus.cs & bus.wr;
    assign avail = (count_q != '0);
    assign full  = (count_q == FIFO_FULL);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then
    assign pop     = rd_en && (bus.addr == 4'h0) && avail;
    assign push    = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem[wptr_q] <= shreg_q;
        end
    end

    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (wr_en && bus.addr == 4'h2) begin
            if (bus.d_in[3]) frame_err_d = 1'b0;
            if (bus.d_in[2]) overrun_d   = 1'b0;
        end
        if (ferr_set) frame_err_d = 1'b1;
        if (ovr_set)  overrun_d   = 1'b1;
    end

    always_comb begin
        d_out_d = d_out_q;
        if (rd_en) begin
            case (bus.addr)
                4'h0:    d_out_d = avail ? {8'h00, mem[rptr_q]} : 16'h0000;
                4'h2:    d_out_d = {12'h000, frame_err_q, overrun_q, full, avail};
                default: d_out_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            d_out_q     <= 16'h0000;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            d_out_q     <= d_out_d;
        end
    end

    assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_uart_rx_periph.sv
// tb/tb_uart_rx_periph.sv - directed self-checking bench for uart_rx_periph
`timescale 1ns/1ps
module tb_uart_rx_periph;

    localparam int BIT_NS = 8640;

    logic sys_clk_i = 1'b0;
    logic sys_rst_i = 1'b1;
    logic uart_rx   = 1'b1;
    logic rx_led;
    int   n_cmp     = 0;
    int   n_fail    = 0;

    uart_rx_periph_if bus ();

    uart_rx_periph #(
        .CLK_HZ    (50000000),
        .BAUD      (115200),
        .FIFO_DEPTH(4)
    ) dut (
        .sys_clk_i(sys_clk_i),
        .sys_rst_i(sys_rst_i),
        .uart_rx  (uart_rx),
        .bus      (bus.master),
        .rx_led   (rx_led)
    );

    always #10 sys_clk_i = ~sys_clk_i;

    task automatic bus_read(input logic [3:0] a, output logic [15:0] data);
        @(negedge sys_clk_i);
        bus.cs   = 1'b1;
        bus.rd   = 1'b1;
        bus.addr = a;
        @(negedge sys_clk_i);
        bus.cs   = 1'b0;
        bus.rd   = 1'b0;
        data     = bus.d_out;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] data);
        @(negedge sys_clk_i);
        bus.cs   = 1'b1;
        bus.wr   = 1'b1;
        bus.addr = a;
        bus.d_in = data;
        @(negedge sys_clk_i);
        bus.cs   = 1'b0;
        bus.wr   = 1'b0;
        bus.d_in = 16'h0000;
    endtask

    // Drives one frame; optionally checks rx_led at the middle of every bit
    task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit chk_led);
        uart_rx = 1'b0;
        #(BIT_NS / 2);
        if (chk_led) begin
            if (rx_led !== 1'b1) begin
                $display("FAIL led_start: rx_led=%b expected 1", rx_led);
                n_fail++;
            end
            n_cmp++;
        end
        #(BIT_NS / 2);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #(BIT_NS / 2);
            if (chk_led) begin
                if (rx_led !== 1'b1) begin
                    $display("FAIL led_bit%0d: rx_led=%b expected 1", i, rx_led);
                    n_fail++;
                end
                n_cmp++;
            end
            #(BIT_NS / 2);
        end
        if (bad_stop) begin
            uart_rx = 1'b0;
            #(2 * BIT_NS);
            uart_rx = 1'b1;
            #(BIT_NS);
        end else begin
            uart_rx = 1'b1;
            #(BIT_NS / 4);
            if (chk_led) begin
                if (rx_led !== 1'b1) begin
                    $display("FAIL led_stop: rx_led=%b expected 1", rx_led);
                    n_fail++;
                end
                n_cmp++;
            end
            #(3 * BIT_NS / 4);
        end
        #(BIT_NS);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        #33;
        if (bus.d_out !== 16'h0000) begin
            $display("FAIL reset_dout: d_out=%h expected 0000", bus.d_out);
            n_fail++;
        end
        n_cmp++;
        if (rx_led !== 1'b0) begin
            $display("FAIL reset_led: rx_led=%b expected 0", rx_led);
            n_fail++;
        end
        n_cmp++;
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        repeat (4) @(negedge sys_clk_i);
        bus_read(4'h2, v);
        if (v !== 16'h0000) begin
            $display("FAIL reset_status: d_out=%h expected 0000", v);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_single();
        logic [15:0] v;
        send_frame(8'hA5, 1'b0, 1'b1);
        if (rx_led !== 1'b0) begin
            $display("FAIL single_led_idle: rx_led=%b expected 0", rx_led);
            n_fail++;
        end
        n_cmp++;
        bus_read(4'h2, v);
        if (v !== 16'h0001) begin
            $display("FAIL single_status: d_out=%h expected 0001", v);
            n_fail++;
        end
        n_cmp++;
        bus_read(4'h0, v);
        if (v !== 16'h00A5) begin
            $display("FAIL single_data: d_out=%h expected 00a5", v);
            n_fail++;
        end
        n_cmp++;
        bus_read(4'h2, v);
        if (v !== 16'h0000) begin
            $display("FAIL single_status_after: d_out=%h expected 0000", v);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_glitch();
        logic [15:0] v;
        uart_rx = 1'b0;
        #1620;
        uart_rx = 1'b1;
        #(2 * BIT_NS);
        if (rx_led !== 1'b0) begin
            $display("FAIL glitch_led: rx_led=%b expected 0", rx_led);
            n_fail++;
        end
        n_cmp++;
        bus_read(4'h2, v);
        if (v !== 16'h0000) begin
            $display("FAIL glitch_status: d_out=%h expected 0000", v);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_overrun();
        logic [15:0] v;
        logic [7:0]  bytes [5];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55;
        for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b0, 1'b0);
        bus_read(4'h2, v);
        if (v !== 16'h0007) begin
            $display("FAIL ovr_status_full: d_out=%h expected 0007", v);
            n_fail++;
        end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            bus_read(4'h0, v);
            if (v !== {8'h00, bytes[i]}) begin
                $display("FAIL ovr_data%0d: d_out=%h expected %h", i, v, {8'h00, bytes[i]});
                n_fail++;
            end
            n_cmp++;
        end
        bus_read(4'h0, v);
        if (v !== 16'h0000) begin
            $display("FAIL ovr_empty_read: d_out=%h expected 0000", v);
            n_fail++;
        end
        n_cmp++;
        bus_read(4'h2, v);
        if (v !== 16'h0004) begin
            $display("FAIL ovr_status_sticky: d_out=%h expected 0004", v);
            n_fail++;
        end
        n_cmp++;
        bus_write(4'h2, 16'h0004);
        bus_read(4'h2, v);
        if (v !== 16'h0000) begin
            $display("FAIL ovr_cleared: d_out=%h expected 0000", v);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_frame_err();
        logic [15:0] v;
        send_frame(8'h3C, 1'b1, 1'b0);
        bus_read(4'h2, v);
        if (v !== 16'h0008) begin
            $display("FAIL ferr_status: d_out=%h expected 0008", v);
            n_fail++;
        end
        n_cmp++;
        bus_write(4'h3, 16'h000C);
        bus_read(4'h1, v);
        if (v !== 16'h0000) begin
            $display("FAIL ferr_other_addr: d_out=%h expected 0000", v);
            n_fail++;
        end
        n_cmp++;
        bus_read(4'h2, v);
        if (v !== 16'h0008) begin
            $display("FAIL ferr_no_side_effect: d_out=%h expected 0008", v);
            n_fail++;
        end
        n_cmp++;
        send_frame(8'h7E, 1'b0, 1'b0);
        bus_read(4'h2, v);
        if (v !== 16'h0009) begin
            $display("FAIL ferr_next_status: d_out=%h expected 0009", v);
            n_fail++;
        end
        n_cmp++;
        bus_read(4'h0, v);
        if (v !== 16'h007E) begin
            $display("FAIL ferr_next_data: d_out=%h expected 007e", v);
            n_fail++;
        end
        n_cmp++;
        bus_write(4'h2, 16'h0008);
        bus_read(4'h2, v);
        if (v !== 16'h0000) begin
            $display("FAIL ferr_cleared: d_out=%h expected 0000", v);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] v;
        logic [7:0]  b;
        send_frame(8'h5A, 1'b0, 1'b0);
        bus_read(4'h2, v);
        if (v !== 16'h0001) begin
            $display("FAIL rstmid_pre_status: d_out=%h expected 0001", v);
            n_fail++;
        end
        n_cmp++;
        b = 8'hF0;
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            uart_rx = b[i];
            #(BIT_NS);
        end
        uart_rx = b[4];
        #(BIT_NS / 2);
        #3;
        sys_rst_i = 1'b1;
        #3;
        if (bus.d_out !== 16'h0000) begin
            $display("FAIL rstmid_dout: d_out=%h expected 0000", bus.d_out);
            n_fail++;
        end
        n_cmp++;
        if (rx_led !== 1'b0) begin
            $display("FAIL rstmid_led: rx_led=%b expected 0", rx_led);
            n_fail++;
        end
        n_cmp++;
        #100;
        uart_rx = 1'b1;
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        #(2 * BIT_NS);
        bus_read(4'h2, v);
        if (v !== 16'h0000) begin
            $display("FAIL rstmid_post_status: d_out=%h expected 0000", v);
            n_fail++;
        end
        n_cmp++;
        send_frame(8'h81, 1'b0, 1'b0);
        bus_read(4'h2, v);
        if (v !== 16'h0001) begin
            $display("FAIL rstmid_new_status: d_out=%h expected 0001", v);
            n_fail++;
        end
        n_cmp++;
        bus_read(4'h0, v);
        if (v !== 16'h0081) begin
            $display("FAIL rstmid_new_data: d_out=%h expected 0081", v);
            n_fail++;
        end
        n_cmp++;
    endtask

    initial begin
        bus.cs   = 1'b0;
        bus.rd   = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = 4'h0;
        bus.d_in = 16'h0000;
        test_reset();
        test_single();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_periph.md
UART_RX_PERIPH -- requirements
Module: uart_rx_periph

Interface
REQ-001 Parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two.
REQ-004 Port sys_clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005 Port sys_rst_i  input  1: reset; asynchronous, active-high.
REQ-006 Port uart_rx  input  1: asynchronous serial line; idles high; 8N1 framing.
REQ-007 Port cs  input  1: peripheral select from the J1 SoC bus decoder.
REQ-008 Port rd  input  1: read strobe; qualified by cs.
REQ-009 Port wr  input  1: write strobe; qualified by cs.
REQ-010 Port addr  input  4: register address.
REQ-011 Port d_in  input  16: write data.
REQ-012 Port d_out  output  16: registered read data.
REQ-013 Port rx_led  output  1: high while a frame is being received.

Function
REQ-014 Tick divider: DIV = CLK_HZ/(BAUD*16), integer-truncated (27 at the defaults); one-cycle tick when the counter wraps DIV-1->0; the counter free-runs outside IDLE and is held at 0 in IDLE.
REQ-015 uart_rx passes through a 2-flop synchronizer reset to 1; all logic uses the synchronized value rxs.
REQ-016 FSM states: IDLE, START, DATA, STOP; 4-bit tick counter tcnt, 3-bit bit index bidx.
REQ-017 IDLE: rxs==0 -> START, tcnt=0, divider restarted.
REQ-018 START: at tcnt==7, rxs==0 -> DATA with tcnt=0 and bidx=0; rxs==1 -> IDLE (glitch rejected, nothing recorded).
REQ-019 DATA: on each tcnt==15 tick, shift rxs in LSB-first; after bidx==7 -> STOP with tcnt=0.
REQ-020 STOP: at tcnt==15, rxs==1 -> push byte and go IDLE; rxs==0 -> set frame_err, discard byte, remain in STOP until rxs==1, then go IDLE.
REQ-021 rx_led = (state != IDLE), registered.
REQ-022 FIFO: FIFO_DEPTH x 8, wrap-around pointers, count 0..FIFO_DEPTH; avail = count!=0; full = count==FIFO_DEPTH.
REQ-023 Push while full and no same-cycle pop: byte dropped, overrun sticky set, FIFO contents unchanged.
REQ-024 Same-cycle push and pop while full: both take effect; count unchanged; no overrun.
REQ-025 Same-cycle push and pop while empty: the pop returns 0x0000 and the pushed byte is retained (count becomes 1).
REQ-026 Read addr 0x0 (cs&rd): d_out = {8'h00, head byte} on the next clock edge and the head is popped; if empty, d_out = 0x0000 and no pop.
REQ-027 Read addr 0x2: d_out = {12'h000, frame_err, overrun, full, avail} on the next clock edge.
REQ-028 Write addr 0x2 (cs&wr): d_in[3]=1 clears frame_err; d_in[2]=1 clears overrun; a set event in the same cycle wins over the clear.
REQ-029 Reads or writes to other addresses: d_out = 0x0000; no side effects; d_out holds its last value when there is no read.

Reset
REQ-030 On sys_rst_i high, immediately: state=IDLE; synchronizer=1; tcnt, bidx, divider, and pointers reset; count=0; frame_err=0; overrun=0; d_out=0x0000; rx_led=0.
REQ-031 Reset mid-frame abandons the partial byte; after release, a frame is recognized only on a new falling edge.

Verification
REQ-032 Send 0xA5 at 8640 ns/bit -> rx_led high for the whole frame; status reads 0x0001; data read returns 0x00A5; then status reads 0x0000.
REQ-033 Low pulse of 3 bit-ticks (~1.6 us) on idle line -> returns to IDLE; status stays 0x0000; no byte pushed.
REQ-034 Send 0x11, 0x22, 0x33, 0x44, 0x55 without reading -> status 0x0007; reads return 0x0011, 0x0022, 0x0033, 0x0044, then 0x0000; write 0x0004 to addr 0x2 -> overrun cleared.
REQ-035 Frame 0x3C with stop bit held low for 2 bit times -> frame_err set; no push; the next valid frame 0x7E is received correctly; write 0x0008 clears frame_err.
REQ-036 Assert sys_rst_i during DATA bit 4 of a frame -> all outputs are 0 asynchronously; after release, the next clean frame 0x81 is read back exactly.
